// File: rtl/slice_feeder_pkg.sv
// ============================================================================
//  Module      : slice_feeder_pkg
//  Description : Shared state encoding and default geometry for slice_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slice_feeder_pkg;

    localparam int C_SLICE_W = 25;
    localparam int C_DEPTH   = 64;
    localparam int C_IDX_W   = 6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DRAIN     = 3'd2,
        READY     = 3'd3,
        EXHAUSTED = 3'd4
    } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/slice_feeder_if.sv
// ============================================================================
//  Module      : slice_feeder_if
//  Description : Input-memory read bus plus the per-line request/response bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slice_feeder_if
    import slice_feeder_pkg::*;
#(
    parameter int SLICE_W = C_SLICE_W,
    parameter int IDX_W   = C_IDX_W
) ();

    logic               mem_rd;
    logic [IDX_W-1:0]   mem_addr;
    logic [SLICE_W-1:0] mem_data;
    logic               readLine;
    logic [SLICE_W-1:0] line;
    logic               line_valid;
    logic [IDX_W-1:0]   count;
    logic               last;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        input  readLine,
        output line, line_valid, count, last
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        output readLine,
        input  line, line_valid, count, last
    );

endinterface

`default_nettype wire

// File: rtl/slice_feeder_slice_buffer.sv
// ============================================================================
//  Module      : slice_buffer
//  Description : DEPTH x SLICE_W line buffer, synchronous write and registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_buffer
    import slice_feeder_pkg::*;
#(
    parameter int SLICE_W = C_SLICE_W,
    parameter int DEPTH   = C_DEPTH,
    parameter int IDX_W   = C_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_addr_i,
    input  logic [SLICE_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [IDX_W-1:0]   rd_addr_i,
    output logic [SLICE_W-1:0] rd_data_o
);

    logic [SLICE_W-1:0] mem_q [DEPTH];
    logic [SLICE_W-1:0] rd_data_q;

    // Storage carries no reset so it can map onto plain register files.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register doubles as the served line, so it holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/slice_feeder.sv
// ============================================================================
//  Module      : slice_feeder
//  Description : Bulk-loads DEPTH slices from input memory, then serves one per
//                readLine. Optional checksum port: SLICE_FEEDER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_feeder
    import slice_feeder_pkg::*;
#(
    parameter int SLICE_W = C_SLICE_W,
    parameter int DEPTH   = C_DEPTH,
    parameter int IDX_W   = C_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 loaded,
    output logic                 exhausted,
`ifdef SLICE_FEEDER_CHECKSUM_EN
    output logic [SLICE_W-1:0]   checksum,
`endif
    slice_feeder_if.master       bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    feeder_state_t      state_q, state_d;
    logic [IDX_W-1:0]   fetch_ptr_q, fetch_ptr_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic               line_valid_q, line_valid_d;
    logic               last_q, last_d;
    logic               wr_en_q;
    logic [IDX_W-1:0]   wr_addr_q;
    logic               mem_rd_w;
    logic               rd_accept_w;
    logic               start_accept_w;

    always_comb begin
        state_d        = state_q;
        fetch_ptr_d    = fetch_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        line_valid_d   = 1'b0;
        last_d         = 1'b0;
        mem_rd_w       = 1'b0;
        rd_accept_w    = 1'b0;
        start_accept_w = 1'b0;
        case (state_q)
            IDLE, EXHAUSTED: begin
                // start takes priority; a readLine here is simply dropped
                if (start) begin
                    state_d        = FETCH;
                    fetch_ptr_d    = '0;
                    rd_ptr_d       = '0;
                    start_accept_w = 1'b1;
                end
            end
            FETCH: begin
                mem_rd_w = 1'b1;
                if (fetch_ptr_q == LAST_IDX) begin
                    state_d     = DRAIN;
                    fetch_ptr_d = '0;
                end else begin
                    fetch_ptr_d = fetch_ptr_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                state_d = READY;
            end
            READY: begin
                if (bus.readLine) begin
                    rd_accept_w  = 1'b1;
                    line_valid_d = 1'b1;
                    count_d      = rd_ptr_q;
                    last_d       = (rd_ptr_q == LAST_IDX);
                    // rd_ptr parks on the final index rather than wrapping
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d = EXHAUSTED;
                    end else begin
                        rd_ptr_d = rd_ptr_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_ptr_q  <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            line_valid_q <= 1'b0;
            last_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_ptr_q  <= fetch_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            line_valid_q <= line_valid_d;
            last_q       <= last_d;
            // memory returns data one cycle after the strobe
            wr_en_q      <= mem_rd_w;
            wr_addr_q    <= fetch_ptr_q;
        end
    end

    slice_buffer #(
        .SLICE_W (SLICE_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_q),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (bus.mem_data),
        .rd_en_i   (rd_accept_w),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.line)
    );

`ifdef SLICE_FEEDER_CHECKSUM_EN
    logic [SLICE_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if (start_accept_w) begin
            checksum_q <= '0;
        end else if (wr_en_q) begin
            checksum_q <= checksum_q ^ bus.mem_data;
        end
    end

    assign checksum = checksum_q;
`endif

    assign bus.mem_rd     = mem_rd_w;
    assign bus.mem_addr   = fetch_ptr_q;
    assign bus.line_valid = line_valid_q;
    assign bus.count      = count_q;
    assign bus.last       = last_q;
    assign loaded         = (state_q == READY);
    assign exhausted      = (state_q == EXHAUSTED);

endmodule

`default_nettype wire

// File: tb/tb_slice_feeder.sv
// ============================================================================
//  Module      : tb_slice_feeder
//  Description : Randomized self-checking bench for slice_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slice_feeder;

    localparam int SW = 25;
    localparam int D  = 64;
    localparam int IW = 6;
    localparam int M_IDLE = 0, M_LOAD = 1, M_SERVE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic loaded, exhausted;
`ifdef SLICE_FEEDER_CHECKSUM_EN
    logic [SW-1:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    int rd_cycles = 0;
    int pulses = 0;

    logic [SW-1:0] words [D];

    // reference state: load age k counts cycles since the accepted start
    int            mode = M_IDLE;
    int            k = 0;
    int            served = 0;
    logic          exp_valid = 1'b0;
    logic          exp_last = 1'b0;
    logic [SW-1:0] exp_line = '0;
    int            exp_count = 0;
    logic [SW-1:0] exp_csum = '0;

    always #5 clk = ~clk;

    slice_feeder_if #(.SLICE_W(SW), .IDX_W(IW)) bus ();

    slice_feeder #(.SLICE_W(SW), .DEPTH(D), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .loaded    (loaded),
        .exhausted (exhausted),
`ifdef SLICE_FEEDER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .bus       (bus)
    );

    initial bus.readLine = 1'b0;

    always @(posedge clk) begin
        bus.mem_data <= bus.mem_rd ? words[bus.mem_addr] : SW'($urandom);
    end

    function automatic logic [SW-1:0] xor_all();
        logic [SW-1:0] x = '0;
        for (int i = 0; i < D; i++) x ^= words[i];
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            mode = M_IDLE; k = 0; served = 0;
            exp_valid = 1'b0; exp_last = 1'b0; exp_line = '0; exp_count = 0; exp_csum = '0;
        end else begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            case (mode)
                M_IDLE, M_DONE: if (start) begin mode = M_LOAD; k = 1; served = 0; end
                M_LOAD: begin
                    k++;
                    if (k == D + 2) begin mode = M_SERVE; exp_csum = xor_all(); end
                end
                M_SERVE: if (bus.readLine) begin
                    exp_valid = 1'b1;
                    exp_line  = words[served];
                    exp_count = served;
                    exp_last  = (served == D - 1);
                    served++;
                    if (served == D) mode = M_DONE;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic exp_rd;
        exp_rd = (mode == M_LOAD) && (k <= D);
        chk("mem_rd", 64'(bus.mem_rd), 64'(exp_rd));
        if (exp_rd) chk("mem_addr", 64'(bus.mem_addr), 64'(k - 1));
        chk("loaded", 64'(loaded), 64'(mode == M_SERVE));
        chk("exhausted", 64'(exhausted), 64'(mode == M_DONE));
        chk("line_valid", 64'(bus.line_valid), 64'(exp_valid));
        chk("last", 64'(bus.last), 64'(exp_last));
        chk("count", 64'(bus.count), 64'(exp_count));
        chk("line", 64'(bus.line), 64'(exp_line));
`ifdef SLICE_FEEDER_CHECKSUM_EN
        if (mode != M_LOAD) chk("checksum", 64'(checksum), 64'(exp_csum));
`endif
        if (bus.mem_rd) rd_cycles++;
        if (bus.line_valid) pulses++;
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic start_and_wait(input int fetch_req_mode);
        int lat;
        start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 1;
        while (!loaded && lat < 200) begin
            bus.readLine = (fetch_req_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc();
            lat++;
        end
        bus.readLine = 1'b0;
        chk("load_latency", 64'(lat), 64'(D + 2));
    endtask

    task automatic drain_until_exhausted(input int pattern);
        int n = 0;
        while (!exhausted && n < 2000) begin
            case (pattern)
                0: bus.readLine = 1'b1;
                1: bus.readLine = (n % 5 == 0);
                default: bus.readLine = ($urandom_range(0, 2) != 0);
            endcase
            start = (pattern == 1) && ($urandom_range(0, 6) == 0);
            cyc();
            n++;
        end
        bus.readLine = 1'b0;
        start = 1'b0;
        chk("exhaust_reached", 64'(exhausted), 64'd1);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < D; i++) words[i] = SW'(i * 3 + 1);
        cyc(); cyc(); cyc();
        chk("rst_line_valid", 64'(bus.line_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        rst = 1'b1;
        cyc();

        // full load then back-to-back service
        rd_cycles = 0; pulses = 0;
        start_and_wait(0);
        chk("fetch_cycles", 64'(rd_cycles), 64'd64);
        drain_until_exhausted(0);
        chk("pulses_b2b", 64'(pulses), 64'd64);
        chk("final_count", 64'(bus.count), 64'd63);
        chk("final_line", 64'(bus.line), 64'd190);

        // sparse requests with ignored starts in READY, random requests during fetch
        for (int i = 0; i < D; i++) words[i] = SW'($urandom);
        pulses = 0;
        start_and_wait(1);
        drain_until_exhausted(1);
        chk("pulses_sparse", 64'(pulses), 64'd64);

        for (int i = 0; i < D; i++) words[i] = SW'($urandom);
        start_and_wait(1);
        drain_until_exhausted(2);

        // reset in the middle of serving
        start_and_wait(0);
        bus.readLine = 1'b1;
        repeat (21) cyc();
        bus.readLine = 1'b0;
        chk("count_before_rst", 64'(bus.count), 64'd20);
        rst = 1'b0;
        #1;
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_line", 64'(bus.line), 64'd0);
        chk("rst_count_mid", 64'(bus.count), 64'd0);
        chk("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        start_and_wait(0);
        bus.readLine = 1'b1;
        cyc();
        bus.readLine = 1'b0;
        chk("first_after_rst", 64'(bus.count), 64'd0);
        drain_until_exhausted(2);

        // start and readLine together in EXHAUSTED
        start = 1'b1;
        bus.readLine = 1'b1;
        cyc();
        start = 1'b0;
        bus.readLine = 1'b0;
        chk("ex_line_valid", 64'(bus.line_valid), 64'd0);
        chk("ex_cleared", 64'(exhausted), 64'd0);
        chk("ex_fetching", 64'(bus.mem_rd), 64'd1);
        chk("ex_addr0", 64'(bus.mem_addr), 64'd0);
        while (!loaded) cyc();
        drain_until_exhausted(0);

`ifdef SLICE_FEEDER_CHECKSUM_EN
        for (int i = 0; i < D; i++) words[i] = SW'(1);
        start_and_wait(0);
        chk("csum_even", 64'(checksum), 64'd0);
        drain_until_exhausted(0);
        words[5] = 25'h1FFFFFF;
        start_and_wait(0);
        chk("csum_word5", 64'(checksum), 64'h1FFFFFE);
        drain_until_exhausted(0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slice_feeder.md
Name: slice_feeder

Overview:
- Upstream line source for the permutation-step controller.
- Bulk-loads one full state of DEPTH slices, each SLICE_W bits, from the external input memory into an internal line buffer.
- Then serves one slice per readLine request, together with the slice index, until all slices are consumed.
- Decouples the input memory's timing from the controller's per-line Ydimension/Line handshake.

Parameters:
- SLICE_W, 25, width of one slice/line (5x5 lane bits).
- DEPTH, 64, number of slices per state.
- IDX_W, 6, width of the slice index; must satisfy 2**IDX_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin loading a new state; sampled only in IDLE or EXHAUSTED.
- mem_rd  output  1  read strobe to the input memory.
- mem_addr  output  IDX_W  input-memory slice address.
- mem_data  input  SLICE_W  read data; valid exactly one cycle after mem_rd.
- loaded  output  1  high while the buffer is full and serving (READY state).
- readLine  input  1  request the next slice; one request per cycle.
- line  output  SLICE_W  served slice, registered.
- line_valid  output  1  one-cycle pulse qualifying line/count.
- count  output  IDX_W  index of the slice on line.
- last  output  1  high together with line_valid when count == DEPTH-1.
- exhausted  output  1  high after all DEPTH slices have been served.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - mem_rd=0, mem_addr=0, loaded=0, line=0, line_valid=0, count=0, last=0, exhausted=0.
  - Read and write pointers clear.
  - Buffer contents are don't-care.
- States: IDLE, FETCH, DRAIN, READY, EXHAUSTED.
- IDLE: on start=1, go to FETCH with fetch pointer=0.
- FETCH:
  - mem_rd=1 and mem_addr=fetch pointer every cycle.
  - Fetch pointer increments each cycle.
  - Read data is written to buf[fetch pointer-1] one cycle later.
  - After the cycle that issues address DEPTH-1, go to DRAIN.
- DRAIN:
  - mem_rd=0.
  - Captures the final word into buf[DEPTH-1].
  - Next state READY.
  - Load latency from start to loaded=1 is DEPTH+2 cycles.
- READY:
  - loaded=1.
  - When readLine=1 in cycle t, at t+1: line=buf[rd_ptr], count=rd_ptr, line_valid=1, and last=1 if rd_ptr==DEPTH-1.
  - rd_ptr increments by 1.
  - Back-to-back requests yield back-to-back pulses.
  - line/count hold their values when line_valid is 0.
- EXHAUSTED:
  - Entered when the request for slice DEPTH-1 is accepted; its data pulse still occurs on the next cycle.
  - loaded=0, exhausted=1.
  - readLine is ignored: no line_valid, rd_ptr unchanged.
  - start=1 clears exhausted and rd_ptr, then goes to FETCH.
- start outside IDLE/EXHAUSTED is ignored.
- readLine outside READY is ignored.
- Simultaneous start and readLine in EXHAUSTED: start wins; readLine is dropped.
- Wrap-around: no pointer exceeds DEPTH-1; rd_ptr never wraps inside READY.
- Reset mid-FETCH or mid-READY aborts immediately; no further memory reads occur.

Optional Feature:
- Macro: SLICE_FEEDER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (SLICE_W bits).
  - checksum is the XOR of all words captured during the current load.
  - Cleared to 0 on reset and on each accepted start.
  - Final value is stable from the first READY cycle onward.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding typedef (feeder_state_t: IDLE=0, FETCH=1, DRAIN=2, READY=3, EXHAUSTED=4);
  - default constants SLICE_W=25, DEPTH=64, IDX_W=6, reused by the controller's line/count ports.
- One sub-module: slice_buffer.
  - Synchronous-write, synchronous-read DEPTH x SLICE_W register array.
  - One write port, one read port.
  - Keeps the FSM file focused on sequencing.

Test Plan:
- Memory model word k = k*3 + 1. Pulse start, then issue 64 consecutive readLine -> mem_rd asserted for exactly 64 cycles with addresses 0..63; loaded rises DEPTH+2 cycles after start; line_valid pulses 64 times with count=0..63, line=count*3+1; last=1 only on count=63; exhausted=1 afterwards.
- Sparse readLine (one every 5 cycles) in READY -> each pulse exactly one cycle after its request; line/count hold between pulses; no skipped or duplicated index.
- readLine during FETCH, and start during READY -> no line_valid pulse, no reload (mem_rd stays 0 in READY); served order unaffected.
- rst=0 asserted when count=20 in READY, then start again -> all outputs zero during reset; full reload from address 0; first served count=0.
- In EXHAUSTED assert start and readLine in the same cycle -> no line_valid; FETCH begins; exhausted=0 next cycle.
- With SLICE_FEEDER_CHECKSUM_EN defined and all words = 25'h1 -> checksum=0 (even count of 64). Set word 5 = 25'h1FFFFFF -> checksum=25'h1FFFFFE.
